// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec_unit
//  Description : Two-stage pipelined integer ALU (AND/OR/ADD/SUB) with
//                valid/ready handshakes on both the operand and result sides.
//                Stage 1 captures the operand bundle, stage 2 executes and
//                registers the result and flags that drive the outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       aluCtl,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    localparam logic [3:0] c_OP_AND = 4'b0000;
    localparam logic [3:0] c_OP_OR  = 4'b0001;
    localparam logic [3:0] c_OP_ADD = 4'b0010;
    localparam logic [3:0] c_OP_SUB = 4'b0110;
    localparam int         c_MSB    = WIDTH - 1;

    // Stage 1 (capture) registers
    logic             r_s1_valid;
    logic [3:0]       r_s1_ctl;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;

    // Stage 2 (execute) / output registers
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_overflow;
    logic             r_illegal;

    // Pipeline advance controls
    logic             w_s2_free;
    logic             w_s1_move;
    logic             w_accept;

    // Execute-stage combinational results
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_exec_res;
    logic             w_exec_ovf;
    logic             w_exec_ill;
    logic             w_exec_zero;

    // Stage 2 can take a new bundle when empty or when its current one leaves.
    // in_ready never looks at in_valid, only at occupancy and out_ready.
    assign w_s2_free = !r_s2_valid || out_ready;
    assign w_s1_move = r_s1_valid && w_s2_free;
    assign in_ready  = !r_s1_valid || w_s1_move;
    assign w_accept  = in_valid && in_ready;

    assign w_sum  = r_s1_a + r_s1_b;
    assign w_diff = r_s1_a - r_s1_b;

    // Execute the stage-1 bundle; undefined codes yield a zero result flagged illegal
    always_comb begin
        w_exec_res = '0;
        w_exec_ovf = 1'b0;
        w_exec_ill = 1'b0;
        case (r_s1_ctl)
            c_OP_AND: w_exec_res = r_s1_a & r_s1_b;
            c_OP_OR:  w_exec_res = r_s1_a | r_s1_b;
            c_OP_ADD: begin
                w_exec_res = w_sum;
                w_exec_ovf = (r_s1_a[c_MSB] == r_s1_b[c_MSB]) &&
                             (w_sum[c_MSB] != r_s1_a[c_MSB]);
            end
            c_OP_SUB: begin
                w_exec_res = w_diff;
                w_exec_ovf = (r_s1_a[c_MSB] != r_s1_b[c_MSB]) &&
                             (w_diff[c_MSB] != r_s1_a[c_MSB]);
            end
            default: w_exec_ill = 1'b1;
        endcase
        w_exec_zero = (w_exec_res == '0);
    end

    // Stage 1: load on accept (which also covers reload while advancing),
    // otherwise empty out when the bundle moves on
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_ctl   <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_ctl   <= aluCtl;
            r_s1_a     <= srcA;
            r_s1_b     <= srcB;
        end else if (w_s1_move) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 2: capture executed result when stage 1 advances; otherwise drain
    // on consume, holding the result and flags steady while stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_overflow <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (w_s1_move) begin
            r_s2_valid <= 1'b1;
            r_result   <= w_exec_res;
            r_zero     <= w_exec_zero;
            r_overflow <= w_exec_ovf;
            r_illegal  <= w_exec_ill;
        end else if (out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

    assign out_valid = r_s2_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign overflow  = r_overflow;
    assign illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_exec_unit
//  Description : Self-checking bench for alu_exec_unit with a transaction
//                level reference model (queue of expected results).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

    localparam int c_W = 32;

    typedef struct {
        logic [3:0]     ctl;
        logic [c_W-1:0] a;
        logic [c_W-1:0] b;
    } stim_t;

    typedef struct {
        logic [c_W-1:0] res;
        logic           z;
        logic           o;
        logic           il;
        int             acyc;
    } exp_t;

    typedef struct {
        logic [c_W-1:0] res;
        logic           z;
        logic           o;
        logic           il;
        int             dcyc;
        int             acyc;
    } dlv_t;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [3:0]     aluCtl = 4'd0;
    logic [c_W-1:0] srcA = '0;
    logic [c_W-1:0] srcB = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [c_W-1:0] result;
    logic           zero;
    logic           overflow;
    logic           illegal;

    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    ready_mode = 0;   // 0: out_ready=1, 1: out_ready=0, 2: random
    bit    gap_en = 1'b0;
    bit    accepted_now = 1'b0;
    bit    presenting = 1'b0;
    bit    prev_rst = 1'b0;

    stim_t sq[$];
    exp_t  mq[$];
    dlv_t  dq[$];

    alu_exec_unit #(.WIDTH(c_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluCtl    (aluCtl),
        .srcA      (srcA),
        .srcB      (srcB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
    endtask

    // Reference: signed overflow judged by exact wide arithmetic
    function automatic exp_t model(logic [3:0] c, logic [c_W-1:0] a, logic [c_W-1:0] b);
        exp_t   e;
        longint sa, sb, s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.res = '0; e.o = 1'b0; e.il = 1'b0; e.acyc = 0;
        case (c)
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b0010, 4'b0110: begin
                s = (c == 4'b0010) ? sa + sb : sa - sb;
                e.res = s[c_W-1:0];
                e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            default: e.il = 1'b1;
        endcase
        e.z = (e.res == 0);
        return e;
    endfunction

    // Driver: present queued bundles, hold until accepted, optional idle gaps
    always @(posedge clk) begin
        #1;
        if (accepted_now) begin
            void'(sq.pop_front());
            presenting = 1'b0;
        end
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(1));
        endcase
        if (reset || sq.size() == 0) begin
            in_valid = 1'b0;
            presenting = 1'b0;
        end else if (presenting || !gap_en || $urandom_range(3) != 0) begin
            in_valid = 1'b1;
            aluCtl = sq[0].ctl;
            srcA = sq[0].a;
            srcB = sq[0].b;
            presenting = 1'b1;
        end else begin
            in_valid = 1'b0;
            aluCtl = 4'($urandom);
            srcA = $urandom;
            srcB = $urandom;
        end
    end

    // Compare process: every cycle, check handshake and outputs against model
    always @(negedge clk) begin
        int  inflight;
        bit  exp_ov;
        exp_t e;
        dlv_t d;
        accepted_now = 1'b0;
        if (prev_rst) begin
            chk("rst_out_valid", out_valid, 1'b0);
            chk("rst_result", result, 0);
            chk("rst_flags", {zero, overflow, illegal}, 3'b000);
            chk("rst_in_ready", in_ready, 1'b1);
        end
        if (reset) begin
            mq.delete();
            prev_rst = 1'b1;
        end else begin
            prev_rst = 1'b0;
            inflight = mq.size();
            chk("in_ready", in_ready, (inflight < 2) || out_ready);
            exp_ov = (inflight > 0) && (cyc >= mq[0].acyc + 2);
            chk("out_valid", out_valid, exp_ov);
            if (out_valid && inflight > 0) begin
                chk("result", result, mq[0].res);
                chk("zero", zero, mq[0].z);
                chk("overflow", overflow, mq[0].o);
                chk("illegal", illegal, mq[0].il);
                if (out_ready) begin
                    d.res = result; d.z = zero; d.o = overflow; d.il = illegal;
                    d.dcyc = cyc; d.acyc = mq[0].acyc;
                    dq.push_back(d);
                    void'(mq.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                e = model(aluCtl, srcA, srcB);
                e.acyc = cyc;
                mq.push_back(e);
                accepted_now = 1'b1;
            end
        end
    end

    task automatic wait_deliv(int n, int maxc, string nm);
        bit ok = 1'b0;
        for (int k = 0; k < maxc; k++) begin
            if (dq.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
        end
        #2;
        if (!ok) fail_now(nm);
    endtask

    task automatic wait_idle(int maxc, string nm);
        bit ok = 1'b0;
        for (int k = 0; k < maxc; k++) begin
            if (sq.size() == 0 && mq.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
        end
        #2;
        if (!ok) fail_now(nm);
    endtask

    task automatic run_one(string nm, logic [3:0] c, logic [c_W-1:0] a, logic [c_W-1:0] b,
                           logic [c_W-1:0] er, logic ez, logic eo, logic ei);
        stim_t s;
        dq.delete();
        s.ctl = c; s.a = a; s.b = b;
        sq.push_back(s);
        wait_deliv(1, 50, nm);
        if (dq.size() >= 1) begin
            chk({nm, "_res"}, dq[0].res, er);
            chk({nm, "_zero"}, dq[0].z, ez);
            chk({nm, "_ovf"}, dq[0].o, eo);
            chk({nm, "_ill"}, dq[0].il, ei);
            chk({nm, "_lat"}, dq[0].dcyc - dq[0].acyc, 2);
        end
    endtask

    function automatic logic [c_W-1:0] rnd_word();
        logic [c_W-1:0] corners [5];
        corners[0] = 32'h7FFF_FFFF; corners[1] = 32'h8000_0000;
        corners[2] = 32'hFFFF_FFFF; corners[3] = 32'h0; corners[4] = 32'h1;
        if ($urandom_range(3) == 0) return corners[$urandom_range(4)];
        return $urandom;
    endfunction

    initial begin
        stim_t s;
        logic [3:0] legal [4];
        legal[0] = 4'b0000; legal[1] = 4'b0001; legal[2] = 4'b0010; legal[3] = 4'b0110;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        // Directed single operations
        run_one("add_5_7", 4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 1'b0);
        run_one("sub_9_9", 4'b0110, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0, 1'b0);
        run_one("and", 4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0, 1'b0);
        run_one("or", 4'b0001, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0, 1'b0, 1'b0);
        run_one("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        run_one("sub_ovf", 4'b0110, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        run_one("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1'b0);
        run_one("illegal", 4'b1111, 32'd3, 32'd4, 32'd0, 1'b1, 1'b0, 1'b1);

        // Streaming: 8 back-to-back ADDs
        dq.delete();
        for (int i = 0; i < 8; i++) begin
            s.ctl = 4'b0010; s.a = i; s.b = i;
            sq.push_back(s);
        end
        wait_deliv(8, 60, "stream");
        if (dq.size() >= 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("stream_res", dq[i].res, 2 * i);
                chk("stream_cycle", dq[i].dcyc - dq[0].dcyc, i);
            end
        end

        // Back-pressure: stall output, expect 2 in flight and stable output
        dq.delete();
        ready_mode = 1;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            s.ctl = 4'b0010; s.a = 32'd100; s.b = i;
            sq.push_back(s);
        end
        repeat (10) @(posedge clk);
        #3;
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_out_valid", out_valid, 1'b1);
        chk("bp_result", result, 32'd100);
        chk("bp_pending", sq.size(), 2);
        ready_mode = 0;
        wait_deliv(4, 60, "bp_drain");
        if (dq.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("bp_order", dq[i].res, 100 + i);
        end
        chk("bp_count", dq.size(), 4);

        // Reset with two bundles in flight
        dq.delete();
        ready_mode = 1;
        repeat (2) @(posedge clk);
        s.ctl = 4'b0010; s.a = 32'd1; s.b = 32'd1; sq.push_back(s);
        s.ctl = 4'b0010; s.a = 32'd2; s.b = 32'd2; sq.push_back(s);
        repeat (8) @(posedge clk);
        #3;
        chk("mid_inflight", mq.size(), 2);
        @(posedge clk);
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        ready_mode = 0;
        repeat (6) @(posedge clk);
        #2;
        chk("mid_no_result", dq.size(), 0);
        run_one("post_rst_sub", 4'b0110, 32'd10, 32'd3, 32'd7, 1'b0, 1'b0, 1'b0);

        // Randomized traffic with random back-pressure and input gaps
        gap_en = 1'b1;
        ready_mode = 2;
        for (int i = 0; i < 300; i++) begin
            s.ctl = ($urandom_range(4) == 0) ? 4'($urandom) : legal[$urandom_range(3)];
            s.a = rnd_word();
            s.b = rnd_word();
            sq.push_back(s);
        end
        wait_idle(4000, "random_drain");
        ready_mode = 0;
        gap_en = 1'b0;
        repeat (4) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Two-stage pipelined integer ALU that executes the 4-bit ALU control code produced by the ALU control decoder.
- Operates on two WIDTH-bit operands and returns result, zero, overflow and illegal-code flags.
- Sits between register-read/operand-mux and writeback/branch logic.
- Valid/ready handshakes on both sides so downstream stalls back-pressure the decoder.

Parameters:
- WIDTH, 32, operand and result width in bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand/control bundle valid.
- in_ready  output  1  unit can accept a bundle this cycle.
- aluCtl  input  4  ALU operation code.
- srcA  input  WIDTH  operand A.
- srcB  input  WIDTH  operand B.
- out_valid  output  1  result bundle valid.
- out_ready  input  1  consumer accepts result this cycle.
- result  output  WIDTH  operation result.
- zero  output  1  result == 0.
- overflow  output  1  signed overflow, ADD/SUB only.
- illegal  output  1  aluCtl was not a defined code.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset:
  - s1_valid = 0, s2_valid = 0.
  - out_valid = 0; result, zero, overflow and illegal = 0.
  - in_ready = 1 from the first cycle after reset deasserts.
- Codes:
  - 4'b0000 AND: A & B.
  - 4'b0001 OR: A | B.
  - 4'b0010 ADD: A + B, modulo 2^WIDTH.
  - 4'b0110 SUB: A - B, modulo 2^WIDTH.
  - Any other code: result = 0, illegal = 1, overflow = 0, zero = 1.
- Overflow:
  - ADD: A[msb] == B[msb] and result[msb] != A[msb].
  - SUB: A[msb] != B[msb] and result[msb] != A[msb].
  - AND/OR: 0.
- Stage 1 (capture): registers aluCtl, srcA and srcB on accept (in_valid && in_ready); sets s1_valid.
- Stage 2 (execute): computes from the stage-1 registers; registers result and flags into the output registers; sets s2_valid.
  - out_valid = s2_valid.
  - Output registers drive the ports directly; no combinational path from inputs to outputs.
- Advance rules, evaluated in the same cycle:
  - s2_free = !s2_valid || out_ready.
  - s1_move = s1_valid && s2_free.
  - in_ready = !s1_valid || s1_move.
  - in_ready depends on out_ready combinationally; there is no combinational path from in_valid to in_ready.
- Latency:
  - Bundle accepted in cycle N gives out_valid in cycle N+2 if unstalled.
  - Throughput is 1 bundle/cycle when out_ready is held high.
- Back-pressure:
  - While out_valid && !out_ready, result and all flags hold stable.
  - Stage 1 holds its bundle; in_ready drops once stage 1 is occupied and blocked.
  - At most 2 bundles are in flight; none is dropped or duplicated.
- Simultaneous events:
  - Output consumed and stage-1 advance in the same cycle: the output is replaced without a bubble.
  - Accept and stage-1 advance in the same cycle: stage 1 reloads with the new bundle.
- Ordering: results are delivered strictly in acceptance order.
- Reset mid-operation: all in-flight bundles are discarded; out_valid = 0 on the next cycle; no partial result appears.
- in_valid while in_ready = 0: bundle not captured; the producer must hold it.

Test Plan:
- Reset then single ops, out_ready = 1:
  - ADD 5 + 7 -> result 12, zero 0, ovf 0, two cycles after accept.
  - SUB 9 - 9 -> result 0, zero 1.
  - AND 0xF0F0_F0F0 & 0x0FF0_0FF0 -> 0x00F0_00F0.
  - OR 0xF000_0000 | 0x0000_000F -> 0xF000_000F.
- Overflow:
  - ADD 0x7FFF_FFFF + 1 -> 0x8000_0000, ovf 1.
  - SUB 0x8000_0000 - 1 -> 0x7FFF_FFFF, ovf 1.
  - ADD 0xFFFF_FFFF + 1 -> 0, zero 1, ovf 0.
- Illegal code: aluCtl 4'b1111, A = 3, B = 4 -> result 0, zero 1, illegal 1, ovf 0.
- Streaming: 8 back-to-back ADDs (i + i, i = 0..7), out_ready = 1 -> outputs 0, 2, ..., 14 on 8 consecutive cycles, in_ready constantly 1.
- Back-pressure:
  - Hold out_ready = 0 after the first result.
  - in_ready must drop after 2 bundles are accepted; output holds stable.
  - Release out_ready -> remaining results arrive in order with no loss or duplication.
- Reset mid-flight: assert reset with 2 bundles in flight -> out_valid = 0 next cycle; a fresh SUB 10 - 3 afterwards returns 7.
